decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Next-generation RV32I control decoder with a registered ID/EX control bundle and a valid/ready handshake.
//  Decodes instr into the control bundle, detects illegal encodings and counts them.
//  Sits between the fetch/IF-ID register and the execute stage.
//  Supports flush (branch redirect) and downstream backpressure (stall).
// PARAMETERS
//  PC_W   32  width of pc / pc_o
//  CNT_W  8   width of the saturating illegal-instruction counter
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      asynchronous, active-low reset
//  in_valid     in   1      instr/pc valid from IF/ID
//  in_ready     out  1      block can accept this cycle
//  instr        in   32     instruction word
//  pc           in   PC_W   instruction address
//  flush        in   1      kill held entry and this cycle's input
//  out_valid    out  1      bundle valid to EX
//  out_ready    in   1      EX accepts bundle
//  pc_o         out  PC_W   registered pc
//  rd_o,rs1_o,rs2_o out 5   registered register fields
//  funct3_o     out  3      registered funct3
//  funct7b5_o   out  1      registered instr[30]
//  reg_write, mem_write, branch, jump, jalr, alu_src  out 1 each   control bits
//  imm_src      out  3      000 I, 001 S, 010 B, 011 J, 100 U
//  src_a_sel    out  2      00 rs1, 01 pc (auipc), 10 zero (lui)
//  result_src   out  2      00 ALU, 01 mem, 10 pc+4
//  alu_op       out  2      00 add, 01 branch compare, 10 funct decode, 11 M-ext
//  load_type    out  3      000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
//  store_type   out  2      00 sb, 01 sh, 10 sw
//  illegal_o    out  1      registered entry was an illegal encoding
//  illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0; every bundle and field output = 0; illegal_cnt=0.
//  - in_ready = !flush && (!out_valid || out_ready); combinational; no dependence on in_valid.
//  - Accept = in_valid && in_ready. Bundle is registered next edge; latency 1; one accept per cycle at full rate.
//  - out_valid && !out_ready: all outputs hold bit-stable.
//  - flush: next edge out_valid=0. Input ignored that cycle. flush beats accept and out_ready.
//  - Counter: on accept of an illegal instr, illegal_cnt += 1 and saturates at 2^CNT_W-1.
//  - Unaccepted and flushed inputs are never counted.
//  - Illegal encodings: instr[1:0]!=11; unknown opcode; load funct3 in {011,110,111}; store funct3>=011;
//    branch funct3 in {010,011}; jalr funct3!=000;
//    R-type funct7 not 0000000, or 0100000 with funct3 not 000/101;
//    I-type shift (funct3 001/101) with bad funct7.
//  - Illegal entry: illegal_o=1 and a safe NOP bundle (reg_write=mem_write=branch=jump=jalr=0, other bits 0).
//  - Decode table:
//    load  : reg_write=1 imm_src=I alu_src=1 result_src=01 load_type=per funct3
//    store : mem_write=1 imm_src=S alu_src=1 store_type=funct3[1:0]
//    R     : reg_write=1 alu_op=10
//    I-ALU : reg_write=1 imm_src=I alu_src=1 alu_op=10
//    branch: branch=1 imm_src=B alu_op=01
//    jal   : reg_write=1 jump=1 imm_src=J result_src=10
//    jalr  : reg_write=1 jalr=1 imm_src=I alu_src=1 result_src=10
//    lui   : reg_write=1 imm_src=U alu_src=1 src_a_sel=10
//    auipc : reg_write=1 imm_src=U alu_src=1 src_a_sel=01
//  - No X is ever driven. Unlisted bits are 0.
// CONFIGURATION
//  DECODE_M_EXT_EN defined: R-type funct7=0000001 is legal; alu_op=11, reg_write=1.
//  DECODE_M_EXT_EN undefined: that encoding is illegal and alu_op=11 never appears.
// STRUCTURE
//  decode_pkg: opcode localparams, and IMM_*/RES_*/ALUOP_*/LD_*/ST_*/SRCA_* encodings.
//  Sub-module decode_ctrl_lut: pure combinational instr -> {bundle, illegal}.
//  Top: handshake logic, pipeline register, counter.
// TESTING
//  1. Reset mid-stream with out_valid=1 -> out_valid=0, illegal_cnt=0 immediately, without waiting for clk.
//  2. lw x5,8(x2) (0x00812283) accepted, out_ready=1
//     -> next cycle: reg_write=1, result_src=01, load_type=010, rd_o=5, illegal_o=0.
//  3. out_ready=0 for 3 cycles holding a sh -> in_ready=0, outputs stable.
//     out_ready=1 -> next instr accepted that cycle.
//  4. flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not consumed, counter unchanged.
//  5. Illegal words 0x00000000, load funct3=111, and 0x02000033 (M-ext mul)
//     -> illegal_o=1, NOP bundle, illegal_cnt=3 (2 with DECODE_M_EXT_EN; mul gives alu_op=11).
//  6. CNT_W=2, 5 illegal accepts -> illegal_cnt saturates at 3.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcodes, control encodings and ID/EX bundle types for the RV32I decoder.
// Optional M-extension decode is enabled by defining DECODE_M_EXT_EN.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;
    localparam logic [1:0] ALUOP_M   = 2'b11;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [2:0] imm_src;
        logic [1:0] src_a_sel;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [2:0] load_type;
        logic [1:0] store_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       funct7b5;
        ctrl_t      ctrl;
        logic       illegal;
    } id_ex_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Pure combinational RV32I instruction -> control bundle and illegal flag.
// DECODE_M_EXT_EN makes R-type funct7=0000001 a legal M-extension op.
module decode_ctrl_lut
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output id_ex_t      dec
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       ill;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        c   = CTRL_NOP;
        ill = 1'b0;
        unique case (1'b1)
            (instr[1:0] != 2'b11): ill = 1'b1;
            (op == OP_LOAD): begin
                c.reg_write  = 1'b1;
                c.imm_src    = IMM_I;
                c.alu_src    = 1'b1;
                c.result_src = RES_MEM;
                unique case (f3)
                    3'b000:  c.load_type = LD_B;
                    3'b001:  c.load_type = LD_H;
                    3'b010:  c.load_type = LD_W;
                    3'b100:  c.load_type = LD_BU;
                    3'b101:  c.load_type = LD_HU;
                    default: ill = 1'b1;
                endcase
            end
            (op == OP_STORE): begin
                ill          = f3[2] || (f3[1:0] == 2'b11);
                c.mem_write  = 1'b1;
                c.imm_src    = IMM_S;
                c.alu_src    = 1'b1;
                c.store_type = f3[1:0];
            end
            (op == OP_R): begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_FN;
                unique case (1'b1)
                    (f7 == F7_ZERO): ;
                    (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)): ;
`ifdef DECODE_M_EXT_EN
                    (f7 == F7_MUL): c.alu_op = ALUOP_M;
`endif
                    default: ill = 1'b1;
                endcase
            end
            (op == OP_IMM): begin
                // shifts reuse funct7 as an encoding field, everything else is immediate
                ill = (f3 == 3'b001 && f7 != F7_ZERO)
                   || (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT);
                c.reg_write = 1'b1;
                c.imm_src   = IMM_I;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_FN;
            end
            (op == OP_BRANCH): begin
                ill      = (f3 == 3'b010) || (f3 == 3'b011);
                c.branch = 1'b1;
                c.imm_src = IMM_B;
                c.alu_op = ALUOP_BR;
            end
            (op == OP_JAL): begin
                c.reg_write  = 1'b1;
                c.jump       = 1'b1;
                c.imm_src    = IMM_J;
                c.result_src = RES_PC4;
            end
            (op == OP_JALR): begin
                ill          = (f3 != 3'b000);
                c.reg_write  = 1'b1;
                c.jalr       = 1'b1;
                c.imm_src    = IMM_I;
                c.alu_src    = 1'b1;
                c.result_src = RES_PC4;
            end
            (op == OP_LUI): begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_src   = 1'b1;
                c.src_a_sel = SRCA_ZERO;
            end
            (op == OP_AUIPC): begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_src   = 1'b1;
                c.src_a_sel = SRCA_PC;
            end
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.funct3   = f3;
        dec.funct7b5 = instr[30];
        dec.ctrl     = ill ? CTRL_NOP : c;
        dec.illegal  = ill;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID/EX control register with valid/ready handshake, flush and illegal counter.
// Build with DECODE_M_EXT_EN to accept M-extension R-type encodings.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [PC_W-1:0]  pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  pc_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [2:0]       funct3_o,
    output logic             funct7b5_o,
    output logic             reg_write,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic             jalr,
    output logic             alu_src,
    output logic [2:0]       imm_src,
    output logic [1:0]       src_a_sel,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       load_type,
    output logic [1:0]       store_type,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt
);

    id_ex_t            dec;
    id_ex_t            bundle_q, bundle_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    decode_ctrl_lut u_lut (
        .instr (instr),
        .dec   (dec)
    );

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        bundle_d = bundle_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            pc_d     = pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign pc_o        = pc_q;
    assign rd_o        = bundle_q.rd;
    assign rs1_o       = bundle_q.rs1;
    assign rs2_o       = bundle_q.rs2;
    assign funct3_o    = bundle_q.funct3;
    assign funct7b5_o  = bundle_q.funct7b5;
    assign reg_write   = bundle_q.ctrl.reg_write;
    assign mem_write   = bundle_q.ctrl.mem_write;
    assign branch      = bundle_q.ctrl.branch;
    assign jump        = bundle_q.ctrl.jump;
    assign jalr        = bundle_q.ctrl.jalr;
    assign alu_src     = bundle_q.ctrl.alu_src;
    assign imm_src     = bundle_q.ctrl.imm_src;
    assign src_a_sel   = bundle_q.ctrl.src_a_sel;
    assign result_src  = bundle_q.ctrl.result_src;
    assign alu_op      = bundle_q.ctrl.alu_op;
    assign load_type   = bundle_q.ctrl.load_type;
    assign store_type  = bundle_q.ctrl.store_type;
    assign illegal_o   = bundle_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: directed steps plus random traffic vs a reference model.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_decode_ctrl_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic        rw;
        logic        mw;
        logic        br;
        logic        jp;
        logic        jr;
        logic        as;
        logic [2:0]  imm;
        logic [1:0]  sa;
        logic [1:0]  rs;
        logic [1:0]  aop;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o, imm_src, load_type;
    logic        funct7b5_o, reg_write, mem_write, branch, jump, jalr, alu_src;
    logic [1:0]  src_a_sel, result_src, alu_op, store_type;
    logic        illegal_o;
    logic [7:0]  illegal_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_pc_o;
    logic [4:0]  s_rd_o, s_rs1_o, s_rs2_o;
    logic [2:0]  s_funct3_o, s_imm_src, s_load_type;
    logic        s_funct7b5_o, s_reg_write, s_mem_write, s_branch;
    logic        s_jump, s_jalr, s_alu_src;
    logic [1:0]  s_src_a_sel, s_result_src, s_alu_op, s_store_type;
    logic        s_illegal_o;
    logic [1:0]  s_illegal_cnt;

    exp_t obs;
    exp_t m;
    logic m_valid;
    int   m_cnt;
    int   m_cnt2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.PC_W(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
        .reg_write(reg_write), .mem_write(mem_write), .branch(branch),
        .jump(jump), .jalr(jalr), .alu_src(alu_src), .imm_src(imm_src),
        .src_a_sel(src_a_sel), .result_src(result_src), .alu_op(alu_op),
        .load_type(load_type), .store_type(store_type),
        .illegal_o(illegal_o), .illegal_cnt(illegal_cnt)
    );

    decode_ctrl_pipe #(.PC_W(32), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .pc_o(s_pc_o), .rd_o(s_rd_o), .rs1_o(s_rs1_o),
        .rs2_o(s_rs2_o), .funct3_o(s_funct3_o), .funct7b5_o(s_funct7b5_o),
        .reg_write(s_reg_write), .mem_write(s_mem_write), .branch(s_branch),
        .jump(s_jump), .jalr(s_jalr), .alu_src(s_alu_src),
        .imm_src(s_imm_src), .src_a_sel(s_src_a_sel),
        .result_src(s_result_src), .alu_op(s_alu_op),
        .load_type(s_load_type), .store_type(s_store_type),
        .illegal_o(s_illegal_o), .illegal_cnt(s_illegal_cnt)
    );

    assign obs = {pc_o, rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o,
                  reg_write, mem_write, branch, jump, jalr, alu_src,
                  imm_src, src_a_sel, result_src, alu_op,
                  load_type, store_type, illegal_o};

    task automatic chk(input string tag, input logic [79:0] o,
                       input logic [79:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference decode written from the instruction-set rules.
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] p);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        e = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1;
        e.pc = p;
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.f3 = f3;
        e.f7b5 = w[30];
        if (w[1:0] != 2'b11) ok = 0;
        else case (op)
            7'h03: if (f3 == 3 || f3 == 6 || f3 == 7) ok = 0;
                   else begin
                       e.rw = 1; e.as = 1; e.rs = 1; e.imm = 0;
                       e.lt = (f3 == 0) ? 3'd0 : (f3 == 1) ? 3'd1 :
                              (f3 == 2) ? 3'd2 : (f3 == 4) ? 3'd3 : 3'd4;
                   end
            7'h23: if (f3 >= 3) ok = 0;
                   else begin
                       e.mw = 1; e.imm = 1; e.as = 1; e.st = f3[1:0];
                   end
            7'h33: if (f7 == 0) begin e.rw = 1; e.aop = 2; end
                   else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
                       e.rw = 1; e.aop = 2;
                   end
`ifdef DECODE_M_EXT_EN
                   else if (f7 == 7'h01) begin e.rw = 1; e.aop = 3; end
`endif
                   else ok = 0;
            7'h13: if ((f3 == 1 && f7 != 0) ||
                       (f3 == 5 && f7 != 0 && f7 != 7'h20)) ok = 0;
                   else begin e.rw = 1; e.as = 1; e.aop = 2; end
            7'h63: if (f3 == 2 || f3 == 3) ok = 0;
                   else begin e.br = 1; e.imm = 2; e.aop = 1; end
            7'h6F: begin e.rw = 1; e.jp = 1; e.imm = 3; e.rs = 2; end
            7'h67: if (f3 != 0) ok = 0;
                   else begin e.rw = 1; e.jr = 1; e.as = 1; e.rs = 2; end
            7'h37: begin e.rw = 1; e.imm = 4; e.as = 1; e.sa = 2; end
            7'h17: begin e.rw = 1; e.imm = 4; e.as = 1; e.sa = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin
            {e.rw, e.mw, e.br, e.jp, e.jr, e.as} = '0;
            {e.imm, e.sa, e.rs, e.aop, e.lt, e.st} = '0;
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [31:0] w;
        int k;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        w = $urandom();
        k = $urandom_range(0, 10);
        if (k < 9) begin
            w[6:0] = ops[k];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        m = '0;
        m_valid = 0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic step(input logic iv, input logic [31:0] w,
                        input logic [31:0] p, input logic fl,
                        input logic ordy);
        bit rdy;
        bit acc;
        exp_t d;
        in_valid = iv;
        instr = w;
        pc = p;
        flush = fl;
        out_ready = ordy;
        #1;
        rdy = !fl && (!m_valid || ordy);
        acc = iv && rdy;
        d = ref_decode(w, p);
        chk("in_ready", 80'(in_ready), 80'(rdy));
        @(posedge clk);
        if (fl) m_valid = 0;
        else if (acc) begin m_valid = 1; m = d; end
        else if (ordy) m_valid = 0;
        if (acc && d.ill) begin
            if (m_cnt != 255) m_cnt++;
            if (m_cnt2 != 3) m_cnt2++;
        end
        #1;
        chk("out_valid", 80'(out_valid), 80'(m_valid));
        if (m_valid) chk("bundle", 80'(obs), 80'(m));
        chk("illegal_cnt", 80'(illegal_cnt), 80'(m_cnt));
        chk("sat_cnt", 80'(s_illegal_cnt), 80'(m_cnt2));
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_valid", 80'(out_valid), 80'(0));
        chk("reset_bundle", 80'(obs), 80'(0));
        chk("reset_cnt", 80'(illegal_cnt), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        step(1, 32'h00812283, 32'h100, 0, 1);
        chk("lw_fields", 80'({reg_write, result_src, load_type, rd_o, illegal_o}),
            80'({1'b1, 2'b01, 3'b010, 5'd5, 1'b0}));

        step(1, 32'h00611223, 32'h104, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h002081B3, 32'h108, 0, 0);
            chk("stall_hold", 80'({in_ready, mem_write, store_type, pc_o}),
                80'({1'b0, 1'b1, 2'b01, 32'h104}));
        end
        step(1, 32'h002081B3, 32'h108, 0, 1);
        chk("stall_release", 80'({reg_write, pc_o}), 80'({1'b1, 32'h108}));

        step(1, 32'h00000000, 32'h10C, 1, 1);
        chk("flush", 80'({out_valid, illegal_cnt}), 80'({1'b0, 8'd0}));

        step(1, 32'h00000000, 32'h110, 0, 1);
        chk("ill_zero", 80'({illegal_o, reg_write, mem_write}), 80'(3'b100));
        step(1, 32'h00007003, 32'h114, 0, 1);
        chk("ill_ld111", 80'({illegal_o, reg_write, result_src}), 80'(4'b1000));
        step(1, 32'h02000033, 32'h118, 0, 1);
`ifdef DECODE_M_EXT_EN
        chk("mul", 80'({illegal_o, reg_write, alu_op, illegal_cnt}),
            80'({1'b0, 1'b1, 2'b11, 8'd2}));
`else
        chk("mul", 80'({illegal_o, reg_write, alu_op, illegal_cnt}),
            80'({1'b1, 1'b0, 2'b00, 8'd3}));
`endif
        step(1, 32'hFFFFFFFF, 32'h11C, 0, 1);
        step(1, 32'h40001013, 32'h120, 0, 1);
        chk("sat", 80'(s_illegal_cnt), 80'(2'd3));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end

        step(1, 32'h00812283, 32'h200, 0, 0);
        chk("pre_reset_valid", 80'(out_valid), 80'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 80'({out_valid, illegal_cnt, s_illegal_cnt}), 80'(0));
        chk("async_rst_bundle", 80'(obs), 80'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, 32'h00000013, 32'h300, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
